// File: rtl/pwm_sequencer_pkg.sv
// Shared types for the PWM step sequencer.
//   state_t      : sequencer control state (IDLE, RUN)
//   step_entry_t : one table entry {compare, repeat_count}. Fields are sized
//                  for the widest supported counter; each instance keeps only
//                  its own CB/RB low bits meaningful.
//   clamp_steps  : maps a requested step count onto 1..depth
package pwm_sequencer_pkg;

  localparam int unsigned ENTRY_FIELD_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [ENTRY_FIELD_W-1:0] compare;
    logic [ENTRY_FIELD_W-1:0] repeat_count;
  } step_entry_t;

  // A request of 0 steps still plays one step; oversize requests play the table.
  function automatic int unsigned clamp_steps(input int unsigned requested,
                                              input int unsigned depth);
    if (requested == 0) return 1;
    if (requested > depth) return depth;
    return requested;
  endfunction

endpackage

// File: rtl/pwm_sequencer_timer_counter.sv
// Free-running period counter: counts 0..top_value while enabled, then wraps.
//   clock         : rising-edge clock
//   reset         : synchronous clear to 0 (active-high)
//   enable        : advance the count this cycle
//   top_value     : last count value of a period
//   compare_value : value compared against count
//   count         : current count
//   compare_match : count == compare_value
module timer_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] top_value,
  input  logic [WIDTH-1:0] compare_value,
  output logic [WIDTH-1:0] count,
  output logic             compare_match
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (enable) begin
      // >= rather than == so a count can never run past a lowered top.
      if (count >= top_value) count <= '0;
      else                    count <= count + 1'b1;
    end
  end

  assign compare_match = (count == compare_value);

endmodule

// File: rtl/pwm_sequencer.sv
// Table-driven PWM sequencer. A small table of {compare, repeat} entries is
// written while idle; a start pulse plays entries 0..step_count-1, each for
// repeat+1 PWM periods of top_value+1 cycles, optionally looping.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   start, stop           : begin from step 0 / abort (pulses)
//   loop_enable           : wrap to step 0 after the last step
//   top_value, step_count : period top and active step count, latched at start
//   wr_valid/wr_ready     : table write handshake (ready only while idle)
//   wr_index, wr_compare, wr_repeat : table write data
//   pwm_out               : PWM output
//   busy                  : sequence running
//   step_index            : current step
//   done                  : one-cycle pulse after a non-looping sequence ends
module pwm_sequencer
  import pwm_sequencer_pkg::*;
#(
  parameter  int unsigned MAX_COUNTER_VALUE = 255,
  parameter  int unsigned NUM_STEPS         = 8,
  parameter  int unsigned MAX_REPEAT        = 255,
  localparam int unsigned CB = $clog2(MAX_COUNTER_VALUE + 1),
  localparam int unsigned SB = $clog2(NUM_STEPS),
  localparam int unsigned RB = $clog2(MAX_REPEAT + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          loop_enable,
  input  logic [CB-1:0] top_value,
  input  logic [SB:0]   step_count,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [SB-1:0] wr_index,
  input  logic [CB-1:0] wr_compare,
  input  logic [RB-1:0] wr_repeat,
  output logic          pwm_out,
  output logic          busy,
  output logic [SB-1:0] step_index,
  output logic          done
);

  state_t        state_q, state_d;
  step_entry_t   table_q [NUM_STEPS];

  logic [CB-1:0] active_top_q;
  logic [CB-1:0] active_cmp_q;
  logic [RB-1:0] repeat_q;
  logic [SB-1:0] last_step_q;
  logic [SB-1:0] step_q;
  logic          done_q;

  logic [CB-1:0] count;
  logic          compare_match;
  logic          timer_clear;

  logic          period_end;
  logic          last_period;
  logic          start_load;
  logic          step_advance;
  logic          step_wrap;
  logic          finish;
  logic          load_entry;
  logic [SB-1:0] next_index;

  int unsigned   steps_eff;
  logic [SB-1:0] last_step_d;

  assign period_end  = (state_q == RUN) && (count == active_top_q);
  assign last_period = period_end && (repeat_q == '0);

  // Next-state and step-sequencing decisions.
  always_comb begin
    state_d      = state_q;
    start_load   = 1'b0;
    step_advance = 1'b0;
    step_wrap    = 1'b0;
    finish       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d    = RUN;
          start_load = 1'b1;
        end
      end
      RUN: begin
        // stop beats any step/sequence boundary landing on the same cycle
        if (stop) begin
          state_d = IDLE;
        end else if (last_period) begin
          if (step_q != last_step_q) begin
            step_advance = 1'b1;
          end else if (loop_enable) begin
            step_wrap = 1'b1;
          end else begin
            finish  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    steps_eff   = clamp_steps(32'(step_count), NUM_STEPS);
    last_step_d = SB'(steps_eff - 1);
  end

  assign load_entry = start_load || step_advance || step_wrap;
  assign next_index = step_advance ? (step_q + 1'b1) : '0;

  // Active period/entry registers carry data only, so they are not reset;
  // every use of them is qualified by state_q == RUN.
  always_ff @(posedge clock) begin
    if (start_load) begin
      active_top_q <= top_value;
      last_step_q  <= last_step_d;
    end
    if (load_entry) begin
      active_cmp_q <= table_q[next_index].compare[CB-1:0];
      repeat_q     <= table_q[next_index].repeat_count[RB-1:0];
    end else if (period_end && (repeat_q != '0)) begin
      repeat_q <= repeat_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      step_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (start_load || step_wrap) step_q <= '0;
      else if (step_advance)       step_q <= step_q + 1'b1;
    end
  end

  // Table survives reset; out-of-range indices complete the handshake but are dropped.
  always_ff @(posedge clock) begin
    if (!reset && wr_valid && wr_ready && (32'(wr_index) < NUM_STEPS)) begin
      table_q[wr_index] <= '{compare:      ENTRY_FIELD_W'(wr_compare),
                             repeat_count: ENTRY_FIELD_W'(wr_repeat)};
    end
  end

  assign timer_clear = reset || start_load || stop;

  timer_counter #(
    .WIDTH(CB)
  ) u_timer (
    .clock         (clock),
    .reset         (timer_clear),
    .enable        (state_q == RUN),
    .top_value     (active_top_q),
    .compare_value (active_cmp_q),
    .count         (count),
    .compare_match (compare_match)
  );

  // Upper entry bits and the timer's compare flag have no consumer here.
  logic unused_bits;
  always_comb begin
    unused_bits = compare_match;
    for (int i = 0; i < NUM_STEPS; i++) begin
      unused_bits = unused_bits ^ (^table_q[i].compare[ENTRY_FIELD_W-1:CB])
                                ^ (^table_q[i].repeat_count[ENTRY_FIELD_W-1:RB]);
    end
  end

  assign pwm_out    = (state_q == RUN) && (count < active_cmp_q);
  assign busy       = (state_q == RUN);
  assign wr_ready   = (state_q == IDLE) && !start;
  assign step_index = step_q;
  assign done       = done_q;

endmodule

// File: doc/pwm_sequencer.md
PWM_SEQUENCER -- requirements
Module: pwm_sequencer

Interface
REQ-001 SHALL have parameter MAX_COUNTER_VALUE, default 255, maximum timer top; CB = $clog2(MAX_COUNTER_VALUE+1).
REQ-002 SHALL have parameter NUM_STEPS, default 8, table depth; SB = $clog2(NUM_STEPS).
REQ-003 SHALL have parameter MAX_REPEAT, default 255, maximum per-step repeat; RB = $clog2(MAX_REPEAT+1).
REQ-004 clock  in  1  clock; all logic on rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  pulse; begin sequence from step 0.
REQ-007 stop  in  1  pulse; abort sequence.
REQ-008 loop_enable  in  1  wrap to step 0 after last step instead of finishing.
REQ-009 top_value  in  CB  PWM period top, latched at start.
REQ-010 step_count  in  SB+1  active steps; latched at start.
REQ-011 wr_valid / wr_ready  in / out  1  table write handshake.
REQ-012 wr_index  in  SB, wr_compare  in  CB, wr_repeat  in  RB  table entry write data.
REQ-013 pwm_out  out  1  PWM output.
REQ-014 busy  out  1  high while sequencing.
REQ-015 step_index  out  SB  current step.
REQ-016 done  out  1  one-cycle pulse at sequence completion.

Function
REQ-017 Table SHALL hold NUM_STEPS entries {compare CB, repeat RB}; write accepted when wr_valid && wr_ready; wr_index >= NUM_STEPS dropped (still handshaken).
REQ-018 wr_ready SHALL equal (state==IDLE && !start); no table writes while running.
REQ-019 FSM states IDLE, RUN; IDLE->RUN on start && !stop; RUN->IDLE on stop, or on last period of last step with loop_enable=0.
REQ-020 On start, SHALL latch top_value, step_count (0 treated as 1, >NUM_STEPS clamped to NUM_STEPS), load entry 0 into active compare/repeat counter, clear timer counter.
REQ-021 Timer counts 0..active_top while RUN (period = top+1 cycles); frozen at 0 in IDLE.
REQ-022 period_end SHALL be RUN && counter == active_top.
REQ-023 pwm_out SHALL be RUN && counter < active_compare, combinational from registered state; compare 0 = always low, compare > top = always high.
REQ-024 Step with repeat value r SHALL last r+1 periods; repeat counter decrements at each period_end.
REQ-025 At period_end with repeat counter 0: advance step_index, load next entry, effective from the following cycle (next period's counter 0).
REQ-026 At last step end: loop_enable=1 -> step 0 reloaded, stay RUN; loop_enable=0 -> IDLE, done=1 for that one cycle.
REQ-027 loop_enable SHALL be sampled at each last-step period_end, not latched.
REQ-028 stop in RUN SHALL go IDLE next cycle, pwm_out low from that cycle, no done pulse; stop wins over simultaneous period_end.
REQ-029 start while RUN SHALL be ignored; start && stop in IDLE SHALL be ignored.
REQ-030 busy SHALL equal state==RUN.

Reset
REQ-031 reset SHALL force IDLE, pwm_out=0, busy=0, done=0, step_index=0, timer counter=0, wr_ready=1 next cycle.
REQ-032 Table contents SHALL be unaffected by reset; reset mid-run aborts without done.
REQ-033 reset SHALL take priority over start, stop and writes.

Structure
REQ-034 Package pwm_sequencer_pkg SHALL define state enum (IDLE, RUN) and step entry struct {compare, repeat}.
REQ-035 Period counter SHALL be one sub-module instance of timer_counter, enable=RUN, reset=reset|start-load|stop, top_value=active_top, compare_value=active_compare; its compare_match unused.
REQ-036 Table SHALL be flop array (no RAM inference required).

Verification
REQ-037 top=9, steps=1, entry0={compare 3, repeat 0}, start -> pwm_out high 3 cycles, low 7, then done pulse, busy low.
REQ-038 top=3, steps=2, {1,1},{3,0}, loop=0 -> pwm pattern 1000 1000 1110, step_index 0,0,1, single done.
REQ-039 Same as 038 with loop=1 for 30 cycles, then stop -> pattern repeats every 12 cycles; pwm_out low and busy low next cycle after stop; no done.
REQ-040 wr_valid held during RUN -> wr_ready=0 until IDLE, write then accepted once; entry readback visible in next run.
REQ-041 Reset asserted mid-step 1 -> all outputs reset values next cycle; new start replays from step 0 with retained table.
REQ-042 compare=0 and compare=top+1 entries -> pwm_out constantly 0 and constantly 1 for whole step.
